// File: rtl/vx_commit_gather_pkg.sv
// Shared types for commit gathering: slot states, instruction tag layout and width helpers.
// Also used by the lane-serializing dispatcher.
package vx_commit_gather_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned UUID_WIDTH = 44;
    localparam int unsigned NR_BITS    = 5;

    typedef enum logic [1:0] {
        SlotIdle,
        SlotAccum,
        SlotPending
    } slot_state_e;

    typedef struct packed {
        logic [UUID_WIDTH-1:0] uuid;
        logic [XLEN-1:0]       pc;
        logic [NR_BITS-1:0]    rd;
        logic                  wb;
    } commit_tag_t;

    // clog2 that never returns zero, so single-entry indices still get one bit
    function automatic int unsigned up_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned pid_width(input int unsigned threads, input int unsigned lanes);
        return up_clog2(threads / lanes);
    endfunction

endpackage

// File: rtl/vx_commit_gather_slot.sv
// One per-warp assembly slot: state, instruction tag and full-warp lane-merge registers.
// The parent only raises wr_en for packets that are legal for the current state.
module vx_commit_gather_slot
    import vx_commit_gather_pkg::*;
#(
    parameter int unsigned NUM_LANES   = 1,
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned PID_WIDTH   = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                wr_en,
    input  logic                                sop,
    input  logic                                eop,
    input  logic [PID_WIDTH-1:0]                pid,
    input  commit_tag_t                         in_tag,
    input  logic [NUM_LANES-1:0]                in_tmask,
    input  logic [NUM_LANES-1:0][XLEN-1:0]      in_data,
    input  logic                                drain,
    output slot_state_e                         state,
    output commit_tag_t                         tag,
    output logic [NUM_THREADS-1:0]              tmask,
    output logic [NUM_THREADS-1:0][XLEN-1:0]    data
);

    localparam int unsigned NUM_PACKETS = NUM_THREADS / NUM_LANES;

    slot_state_e                      state_q, state_d;
    commit_tag_t                      tag_q;
    logic [NUM_THREADS-1:0]           tmask_q, tmask_d;
    logic [NUM_THREADS-1:0][XLEN-1:0] data_q, data_d;

    // drain and wr_en are exclusive: drain needs PENDING, writes need IDLE or ACCUM
    always_comb begin
        state_d = state_q;
        if (drain) begin
            state_d = SlotIdle;
        end else if (wr_en) begin
            state_d = eop ? SlotPending : SlotAccum;
        end
    end

    always_comb begin
        tmask_d = sop ? '0 : tmask_q;
        data_d  = sop ? '0 : data_q;
        for (int p = 0; p < NUM_PACKETS; p++) begin
            if (PID_WIDTH'(p) == pid) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    tmask_d[p*NUM_LANES + l] = in_tmask[l];
                    data_d[p*NUM_LANES + l]  = in_data[l];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SlotIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tmask_q <= tmask_d;
            data_q  <= data_d;
            if (sop) begin
                tag_q <= in_tag;
            end
        end
    end

    assign state = state_q;
    assign tag   = tag_q;
    assign tmask = tmask_q;
    assign data  = data_q;

endmodule

// File: rtl/vx_commit_gather.sv
// Gathers lane-serialized commit packets into one full-warp writeback per instruction,
// draining completed warps round-robin through a registered output.
module vx_commit_gather
    import vx_commit_gather_pkg::*;
#(
    parameter int unsigned NUM_LANES   = 1,
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned NUM_WARPS   = 4,
    parameter int unsigned PID_WIDTH   = pid_width(NUM_THREADS, NUM_LANES),
    parameter int unsigned NW_WIDTH    = up_clog2(NUM_WARPS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             commit_if_valid,
    output logic                             commit_if_ready,
    input  logic [UUID_WIDTH-1:0]            commit_if_uuid,
    input  logic [NW_WIDTH-1:0]              commit_if_wid,
    input  logic [NUM_LANES-1:0]             commit_if_tmask,
    input  logic [XLEN-1:0]                  commit_if_PC,
    input  logic [NR_BITS-1:0]               commit_if_rd,
    input  logic                             commit_if_wb,
    input  logic [PID_WIDTH-1:0]             commit_if_pid,
    input  logic                             commit_if_sop,
    input  logic                             commit_if_eop,
    input  logic [NUM_LANES-1:0][XLEN-1:0]   commit_if_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [UUID_WIDTH-1:0]            out_uuid,
    output logic [NW_WIDTH-1:0]              out_wid,
    output logic [XLEN-1:0]                  out_PC,
    output logic [NR_BITS-1:0]               out_rd,
    output logic                             out_wb,
    output logic [NUM_THREADS-1:0]           out_tmask,
    output logic [NUM_THREADS-1:0][XLEN-1:0] out_data,
    output logic                             err
);

    localparam int unsigned NUM_PACKETS = NUM_THREADS / NUM_LANES;

    slot_state_e                      slot_state [NUM_WARPS];
    commit_tag_t                      slot_tag   [NUM_WARPS];
    logic [NUM_THREADS-1:0]           slot_tmask [NUM_WARPS];
    logic [NUM_THREADS-1:0][XLEN-1:0] slot_data  [NUM_WARPS];
    logic [NUM_WARPS-1:0]             slot_wr, slot_drain, pending;

    commit_tag_t   in_tag;
    slot_state_e   wid_state;
    logic          pid_ok, accept, seq_bad, restart, drop, err_set;
    logic          grant_valid, load;
    logic [NW_WIDTH-1:0] grant, rr_ptr_q, rr_ptr_d;

    logic                             out_valid_q, out_valid_d;
    commit_tag_t                      out_tag_q;
    logic [NW_WIDTH-1:0]              out_wid_q;
    logic [NUM_THREADS-1:0]           out_tmask_q;
    logic [NUM_THREADS-1:0][XLEN-1:0] out_data_q;
    logic                             err_q;

    assign in_tag = '{uuid: commit_if_uuid, pc: commit_if_PC, rd: commit_if_rd, wb: commit_if_wb};

    // An out-of-range wid looks PENDING, so it is simply never accepted
    always_comb begin
        wid_state = SlotPending;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (NW_WIDTH'(w) == commit_if_wid) wid_state = slot_state[w];
        end
    end

    always_comb begin
        pid_ok = 1'b0;
        for (int p = 0; p < NUM_PACKETS; p++) begin
            if (PID_WIDTH'(p) == commit_if_pid) pid_ok = 1'b1;
        end
    end

    assign commit_if_ready = (wid_state != SlotPending);
    assign accept  = commit_if_valid && commit_if_ready;
    assign seq_bad = !commit_if_sop && (wid_state == SlotIdle);
    assign restart = commit_if_sop && (wid_state == SlotAccum);
    assign drop    = !pid_ok || seq_bad;
    assign err_set = accept && (!pid_ok || seq_bad || restart);

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            slot_wr[w] = accept && !drop && (NW_WIDTH'(w) == commit_if_wid);
        end
    end

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            pending[w] = (slot_state[w] == SlotPending);
        end
    end

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_slot
        vx_commit_gather_slot #(
            .NUM_LANES   (NUM_LANES),
            .NUM_THREADS (NUM_THREADS),
            .PID_WIDTH   (PID_WIDTH)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (slot_wr[w]),
            .sop      (commit_if_sop),
            .eop      (commit_if_eop),
            .pid      (commit_if_pid),
            .in_tag   (in_tag),
            .in_tmask (commit_if_tmask),
            .in_data  (commit_if_data),
            .drain    (slot_drain[w]),
            .state    (slot_state[w]),
            .tag      (slot_tag[w]),
            .tmask    (slot_tmask[w]),
            .data     (slot_data[w])
        );
    end

    // Round-robin: first pending slot at or above the pointer, else lowest pending slot
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (!grant_valid && pending[w] && (NW_WIDTH'(w) >= rr_ptr_q)) begin
                grant_valid = 1'b1;
                grant       = NW_WIDTH'(w);
            end
        end
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (!grant_valid && pending[w]) begin
                grant_valid = 1'b1;
                grant       = NW_WIDTH'(w);
            end
        end
    end

    assign load = grant_valid && (!out_valid_q || out_ready);

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            slot_drain[w] = load && (grant == NW_WIDTH'(w));
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (load) begin
            rr_ptr_d = (grant == NW_WIDTH'(NUM_WARPS - 1)) ? '0 : grant + 1'b1;
        end
    end

    assign out_valid_d = load || (out_valid_q && !out_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            err_q       <= err_q || err_set;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            out_tag_q   <= slot_tag[grant];
            out_wid_q   <= grant;
            out_tmask_q <= slot_tmask[grant];
            out_data_q  <= slot_data[grant];
        end
    end

    assign out_valid = out_valid_q;
    assign out_uuid  = out_tag_q.uuid;
    assign out_wid   = out_wid_q;
    assign out_PC    = out_tag_q.pc;
    assign out_rd    = out_tag_q.rd;
    assign out_wb    = out_tag_q.wb;
    assign out_tmask = out_tmask_q;
    assign out_data  = out_data_q;
    assign err       = err_q;

endmodule
